sky130_fd_io__top_power_hvc_seq: RTL
====================================

SKY130_FD_IO__TOP_POWER_HVC_SEQ -- requirements
Module: sky130_fd_io__top_power_hvc_seq

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of sequenced supply channels (legal range 1..16).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 16, meaning the number of consecutive all-present samples required before ramp (legal range 1..1023).
REQ-003 The block SHALL have parameter STEP_CYCLES, default 8, meaning the spacing in cycles between consecutive channel enables (legal range 1..1023).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_B, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port EN, input, 1 bit, synchronous: sequence request (1 = power up, 0 = power down).
REQ-007 The block SHALL have port PWR_DET, input, NCH bits, asynchronous: per-channel supply-present detect.
REQ-008 The block SHALL have port CLR_FAULT, input, 1 bit, synchronous: single-cycle fault clear.
REQ-009 The block SHALL have port SW_EN, output, NCH bits: per-channel pad pass-switch enable (channel k switches P_PAD[k] to P_CORE[k]).
REQ-010 The block SHALL have port PGOOD, output, 1 bit: all channels enabled and stable.
REQ-011 The block SHALL have port FAULT, output, 1 bit: sticky supply-loss indication.
REQ-012 The block SHALL have port STATE, output, 3 bits: current FSM state encoding.

Function
REQ-013 Each PWR_DET bit SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value DET_S.
REQ-014 The FSM SHALL have states OFF, DEBOUNCE, RAMP, ON, SHUTDOWN and FAULT, with all outputs registered.
REQ-015 In OFF, EN=1 with DET_S all-ones SHALL cause a transition to DEBOUNCE with the debounce counter at 0.
REQ-016 In DEBOUNCE, the counter SHALL increment while DET_S is all-ones and clear to 0 on any zero bit; EN=0 SHALL return the FSM to OFF.
REQ-017 The counter reaching DEB_CYCLES SHALL cause a transition to RAMP and set SW_EN[0]; SW_EN[0] SHALL therefore rise DEB_CYCLES+3 cycles after PWR_DET goes all-high with EN=1.
REQ-018 In RAMP, SW_EN[k] SHALL rise exactly STEP_CYCLES cycles after SW_EN[k-1], and enables SHALL only accumulate (thermometer code, never skip a channel).
REQ-019 STEP_CYCLES after SW_EN[NCH-1] rises, the FSM SHALL enter ON and PGOOD SHALL rise; for NCH=1 this is STEP_CYCLES after SW_EN[0].
REQ-020 In RAMP, ON or SHUTDOWN, any DET_S bit at 0 SHALL cause a transition to FAULT: SW_EN cleared to 0, PGOOD=0 and FAULT=1 on the next edge.
REQ-021 A fault event SHALL have priority over an EN deassertion in the same cycle.
REQ-022 In FAULT, CLR_FAULT=1 SHALL cause a transition to OFF and clear FAULT, unless a DET_S bit is 0 in the same cycle, in which case the FSM SHALL remain in FAULT.
REQ-023 In RAMP or ON, EN=0 SHALL cause power-down per REQ-028/REQ-029, and PGOOD SHALL fall on the next edge.
REQ-024 The step and debounce counters SHALL be sized to clog2(max parameter + 1) and SHALL saturate, never wrap.

Reset
REQ-025 RESET_B=0 SHALL asynchronously force state OFF, SW_EN=0, PGOOD=0, FAULT=0, all counters to 0 and all synchronizer flops to 0.
REQ-026 Reset asserted mid-RAMP or mid-ON SHALL drop all SW_EN immediately, without waiting for a clock edge.
REQ-027 Deassertion of RESET_B SHALL be synchronized externally; the block SHALL leave OFF no earlier than 3 cycles after reset release.

Configuration
REQ-028 With SKY130_FD_IO_HVC_SEQ_REVERSE_OFF_EN defined, EN=0 in RAMP or ON SHALL enter SHUTDOWN, clear the highest set SW_EN bit every STEP_CYCLES (first bit on the next edge), and enter OFF one edge after SW_EN reaches 0; EN=1 during SHUTDOWN SHALL be ignored until OFF.
REQ-029 Without SKY130_FD_IO_HVC_SEQ_REVERSE_OFF_EN defined, EN=0 in RAMP or ON SHALL clear all SW_EN and enter OFF on the next edge, and SHUTDOWN SHALL be unreachable.

Structure
REQ-030 Package sky130_fd_io__top_power_hvc_seq_pkg SHALL hold the state enum (3-bit encoding) and the NCH maximum constant.
REQ-031 Sub-module sky130_fd_io__top_power_hvc_seq_sync SHALL implement the NCH-wide 2-flop synchronizer with async active-low reset.

Verification
REQ-032 (NCH=4, DEB=16, STEP=8) The bench SHALL drive EN=1 with PWR_DET=4'hF at cycle 0 and check SW_EN[0] rising at cycle 19, [1] at 27, [2] at 35, [3] at 43, and PGOOD rising at 51.
REQ-033 The bench SHALL drive PWR_DET[1] low for 1 cycle at debounce count 10 and check that the counter restarts and SW_EN[0] is delayed accordingly with no fault.
REQ-034 The bench SHALL drive PWR_DET[2] low while in ON and check SW_EN=0, FAULT=1 and PGOOD=0 3 cycles later, then apply CLR_FAULT with detect still low and check that FAULT holds.
REQ-035 The bench SHALL drive EN=0 in ON and check, with the macro, SW_EN stepping 4'hF, 7, 3, 1, 0 at 8-cycle spacing; and check, without the macro, SW_EN=0 on the next edge.
REQ-036 The bench SHALL assert RESET_B=0 mid-RAMP (SW_EN=4'h3) and check all outputs at 0 before the next CLK edge.
REQ-037 The bench SHALL apply an EN fall and a PWR_DET[0] fall reaching DET_S in the same cycle and check that the FSM enters FAULT, not OFF or SHUTDOWN.

Source files
------------

// File: rtl/sky130_fd_io__top_power_hvc_seq_pkg.sv
// rtl/sky130_fd_io__top_power_hvc_seq_pkg.sv - shared state encoding and limits for the HVC power sequencer
package sky130_fd_io__top_power_hvc_seq_pkg;

    // Largest number of sequenced supply channels the block is built for
    localparam int HVC_NCH_MAX = 16;

    // Sequencer states; the encoding is exposed on the STATE port
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RAMP     = 3'd2,
        ST_ON       = 3'd3,
        ST_SHUTDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } hvc_state_t;

endpackage

// File: rtl/sky130_fd_io__top_power_hvc_seq_sync.sv
// rtl/sky130_fd_io__top_power_hvc_seq_sync.sv - W-wide two-flop synchronizer with async active-low reset
module sky130_fd_io__top_power_hvc_seq_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops resolve metastability on the asynchronous detect inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sky130_fd_io__top_power_hvc_seq.sv
// rtl/sky130_fd_io__top_power_hvc_seq.sv - pad supply pass-switch sequencer (option macro SKY130_FD_IO_HVC_SEQ_REVERSE_OFF_EN)
module sky130_fd_io__top_power_hvc_seq
    import sky130_fd_io__top_power_hvc_seq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DEB_CYCLES  = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic           CLK,
    input  logic           RESET_B,
    input  logic           EN,
    input  logic [NCH-1:0] PWR_DET,
    input  logic           CLR_FAULT,
    output logic [NCH-1:0] SW_EN,
    output logic           PGOOD,
    output logic           FAULT,
    output logic [2:0]     STATE
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [NCH-1:0]    w_det_s;
    logic              w_all_det;

    hvc_state_t        r_state;
    logic [NCH-1:0]    r_sw_en;
    logic              r_pgood;
    logic              r_fault;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [STEP_W-1:0] r_step_cnt;

    sky130_fd_io__top_power_hvc_seq_sync #(
        .W (NCH)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_B),
        .i_d     (PWR_DET),
        .o_q     (w_det_s)
    );

    assign w_all_det = &w_det_s;

    // Sequencer: debounce supply presence, ramp switches on one by one, watch for supply loss
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state    <= ST_OFF;
            r_sw_en    <= '0;
            r_pgood    <= 1'b0;
            r_fault    <= 1'b0;
            r_deb_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_sw_en    <= '0;
                    r_pgood    <= 1'b0;
                    r_step_cnt <= '0;
                    r_deb_cnt  <= '0;
                    if (EN && w_all_det) begin
                        r_state <= ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!EN) begin
                        r_state   <= ST_OFF;
                        r_deb_cnt <= '0;
                    end else if (!w_all_det) begin
                        // Any dropout restarts the stability window
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_MAX) begin
                        r_state    <= ST_RAMP;
                        r_sw_en    <= NCH'(1);
                        r_step_cnt <= '0;
                        r_deb_cnt  <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end

                ST_RAMP, ST_ON: begin
                    if (!w_all_det) begin
                        // Supply loss wins over a simultaneous power-down request
                        r_state    <= ST_FAULT;
                        r_sw_en    <= '0;
                        r_pgood    <= 1'b0;
                        r_fault    <= 1'b1;
                        r_step_cnt <= '0;
                    end else if (!EN) begin
                        r_pgood    <= 1'b0;
                        r_step_cnt <= '0;
`ifdef SKY130_FD_IO_HVC_SEQ_REVERSE_OFF_EN
                        // Drop the most recently enabled channel first
                        r_state <= ST_SHUTDOWN;
                        r_sw_en <= r_sw_en >> 1;
`else
                        r_state <= ST_OFF;
                        r_sw_en <= '0;
`endif
                    end else if (r_state == ST_RAMP) begin
                        if (r_step_cnt == STEP_LAST) begin
                            r_step_cnt <= '0;
                            if (r_sw_en[NCH-1]) begin
                                r_state <= ST_ON;
                                r_pgood <= 1'b1;
                            end else begin
                                // Thermometer growth: next channel only, never a skip
                                r_sw_en <= (r_sw_en << 1) | NCH'(1);
                            end
                        end else if (r_step_cnt != STEP_MAX) begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end

                ST_SHUTDOWN: begin
                    r_pgood <= 1'b0;
                    if (!w_all_det) begin
                        r_state    <= ST_FAULT;
                        r_sw_en    <= '0;
                        r_fault    <= 1'b1;
                        r_step_cnt <= '0;
                    end else if (r_sw_en == '0) begin
                        r_state    <= ST_OFF;
                        r_step_cnt <= '0;
                    end else if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        r_sw_en    <= r_sw_en >> 1;
                    end else if (r_step_cnt != STEP_MAX) begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end

                ST_FAULT: begin
                    r_sw_en    <= '0;
                    r_pgood    <= 1'b0;
                    r_step_cnt <= '0;
                    r_deb_cnt  <= '0;
                    // A clear is refused while any supply is still missing
                    if (CLR_FAULT && w_all_det) begin
                        r_state <= ST_OFF;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_OFF;
                    r_sw_en    <= '0;
                    r_pgood    <= 1'b0;
                    r_step_cnt <= '0;
                    r_deb_cnt  <= '0;
                end
            endcase
        end
    end

    assign SW_EN = r_sw_en;
    assign PGOOD = r_pgood;
    assign FAULT = r_fault;
    assign STATE = r_state;

endmodule
